// File: rtl/lab06_sched_pkg.sv
// Shared types and constants for the lab06 two-requester scheduler.
// The optional WAIT-state timeout is enabled by defining LAB06_SCHED_TIMEOUT_EN.
package lab06_sched_pkg;

  localparam int N_BEATS_DEF     = 4;
  localparam int TIMEOUT_CYC_DEF = 64;
  localparam int REQ_CNT         = 2;
  localparam int RES_W           = 6;
  localparam int NIB_W           = 4;
  localparam int MODE_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_RESP
  } sched_state_e;

  typedef struct packed {
    logic [MODE_W-1:0] mode;
    logic              owner;
  } job_meta_t;

  function automatic logic [REQ_CNT-1:0] owner_onehot(input logic owner);
    logic [REQ_CNT-1:0] oh;
    oh        = '0;
    oh[owner] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/lab06_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves past whichever requester
// was granted whenever the owner of the grant reports an accepted job.
module lab06_rr_arb2
  import lab06_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_CNT-1:0] req,
  input  logic               advance,
  output logic [REQ_CNT-1:0] grant
);

  logic ptr_q;

  always_comb begin
    grant = '0;
    if (!ptr_q) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

  // Granting 0 hands priority to 1 next, and vice versa.
  always_ff @(posedge clk) begin
    if (rst)                    ptr_q <= 1'b0;
    else if (advance && |grant) ptr_q <= grant[0];
  end

endmodule

// File: rtl/lab06_sched.sv
// Round-robin job scheduler in front of one lab06 core: accepts a job, bursts
// its nibbles into the core, returns the result. Timeout: LAB06_SCHED_TIMEOUT_EN.
module lab06_sched
  import lab06_sched_pkg::*;
#(
  parameter int N_BEATS     = N_BEATS_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [REQ_CNT-1:0]                      req_valid,
  output logic [REQ_CNT-1:0]                      req_ready,
  input  logic [REQ_CNT-1:0][NIB_W*N_BEATS-1:0]   req_data,
  input  logic [REQ_CNT-1:0][MODE_W-1:0]          req_mode,
  output logic [REQ_CNT-1:0]                      rsp_valid,
  output logic signed [RES_W-1:0]                 rsp_result,
  output logic                                    rsp_err,
  output logic                                    core_in_valid,
  output logic [NIB_W-1:0]                        core_in_number,
  output logic [MODE_W-1:0]                       core_mode,
  input  logic                                    core_out_valid,
  input  logic signed [RES_W-1:0]                 core_out_result
);

  localparam int BEAT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int OP_W   = NIB_W * N_BEATS;

  if (N_BEATS < 1 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("lab06_sched: N_BEATS and TIMEOUT_CYC must be >= 1");
  end

  sched_state_e         state_q, state_d;
  logic [REQ_CNT-1:0]   grant;
  logic                 accept;
  logic [OP_W-1:0]      ops_q;
  job_meta_t            meta_q;
  logic [BEAT_W-1:0]    beat_q;
  logic signed [RES_W-1:0] res_q;
  logic                 last_beat;
  logic                 tmo_hit;

  lab06_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign accept    = |(req_valid & req_ready);
  assign last_beat = (beat_q == BEAT_W'(N_BEATS - 1));

`ifdef LAB06_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             err_q;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk) begin
    if (rst)                     tmo_q <= '0;
    else if (state_q != ST_WAIT) tmo_q <= '0;
    else                         tmo_q <= tmo_q + 1'b1;
  end

  assign tmo_hit = (state_q == ST_WAIT) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // A core answer on the terminal cycle takes precedence over the abort.
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (state_q == ST_WAIT && (core_out_valid || tmo_hit))
      err_q <= !core_out_valid;
  end

  assign rsp_err = (state_q == ST_RESP) && err_q;
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)                    state_d = ST_SEND;
      ST_SEND: if (last_beat)                 state_d = ST_WAIT;
      ST_WAIT: if (core_out_valid || tmo_hit) state_d = ST_RESP;
      ST_RESP:                                state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q  <= '0;
      meta_q <= '0;
      beat_q <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          ops_q  <= req_data[grant[1]];
          meta_q <= '{mode: req_mode[grant[1]], owner: grant[1]};
          beat_q <= '0;
        end
        // Nibble 0 sits in the low bits, so shifting right walks the burst.
        ST_SEND: begin
          ops_q  <= ops_q >> NIB_W;
          beat_q <= beat_q + 1'b1;
        end
        ST_WAIT: begin
          if (core_out_valid) res_q <= core_out_result;
          else if (tmo_hit)   res_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    core_in_valid  = 1'b0;
    core_in_number = '0;
    core_mode      = '0;
    case (state_q)
      ST_IDLE: if (!rst) req_ready = grant;
      ST_SEND: begin
        core_in_valid  = 1'b1;
        core_in_number = ops_q[NIB_W-1:0];
        core_mode      = meta_q.mode;
      end
      ST_RESP: rsp_valid = owner_onehot(meta_q.owner);
      default: ;
    endcase
  end

  assign rsp_result = res_q;

endmodule

// File: tb/tb_lab06_sched.sv
// Scoreboard bench for lab06_sched: a bench-side core model answers each burst,
// expectations are queued at handshake/last beat and retired at the DUT outputs.
module tb_lab06_sched;
  import lab06_sched_pkg::*;

  localparam int NB = N_BEATS_DEF;
  localparam int TO = TIMEOUT_CYC_DEF;
`ifdef LAB06_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    logic [4*NB-1:0]    data;
    logic [1:0]         mode;
    logic signed [5:0]  res;
    int                 dly;   // core answers dly cycles after last beat; 0 = silent
    bit                 spur;  // inject a stray core_out_valid on SEND beat 1
  } job_t;
  typedef struct { int cyc; logic [3:0] nib; logic [1:0] mode; bit last; } beat_t;
  typedef struct { int cyc; logic [1:0] oh; logic signed [5:0] res; logic err; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0]              req_valid = '0;
  logic [1:0]              req_ready;
  logic [1:0][4*NB-1:0]    req_data  = '0;
  logic [1:0][1:0]         req_mode  = '0;
  logic [1:0]              rsp_valid;
  logic signed [5:0]       rsp_result;
  logic                    rsp_err;
  logic                    core_in_valid;
  logic [3:0]              core_in_number;
  logic [1:0]              core_mode;
  logic                    core_out_valid  = 1'b0;
  logic signed [5:0]       core_out_result = '0;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  job_t  jq[2][$];
  job_t  cur_job[2];
  job_t  infl;
  int    hs_cnt[2];
  int    pop_cnt[2];
  beat_t beat_q[$];
  rsp_t  rsp_q[$];
  bit    busy = 1'b0;
  logic [1:0] own_oh = '0;
  int    fire_at = -1;
  int    spur_at = -1;
  int    res_chk_at = -1;
  logic signed [5:0] last_res = '0;
  int    rr_ptr = 0;
  int    hs_log_r[$];
  int    hs_log_c[$];

  lab06_sched dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_data        (req_data),
    .req_mode        (req_mode),
    .rsp_valid       (rsp_valid),
    .rsp_result      (rsp_result),
    .rsp_err         (rsp_err),
    .core_in_valid   (core_in_valid),
    .core_in_number  (core_in_number),
    .core_mode       (core_mode),
    .core_out_valid  (core_out_valid),
    .core_out_result (core_out_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit is_timeout(input int dly);
    return TMO_EN && (dly == 0 || dly > TO);
  endfunction

  // Requester side: offer head of each queue, retire it once the monitor saw the handshake.
  initial forever begin
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      while (pop_cnt[r] < hs_cnt[r]) begin
        void'(jq[r].pop_front());
        pop_cnt[r]++;
      end
      if (jq[r].size() > 0) begin
        cur_job[r]   = jq[r][0];
        req_valid[r] = 1'b1;
        req_data[r]  = jq[r][0].data;
        req_mode[r]  = jq[r][0].mode;
      end else begin
        req_valid[r] = 1'b0;
      end
    end
  end

  // Core model: one-cycle result strobe, plus optional stray strobes.
  initial forever begin
    @(posedge clk); #1;
    core_out_valid  = 1'b0;
    core_out_result = '0;
    if (cyc == fire_at) begin
      core_out_valid  = 1'b1;
      core_out_result = infl.res;
    end else if (cyc == spur_at) begin
      core_out_valid  = 1'b1;
      core_out_result = 6'sd21;
    end
  end

  always @(negedge clk) begin : mon
    logic [1:0] exp_g, hs, exp_rv;
    bit exp_civ;
    beat_t b;
    rsp_t  rp;
    int g;
    if (rst) begin
      beat_q.delete();
      rsp_q.delete();
      busy       = 1'b0;
      fire_at    = -1;
      spur_at    = -1;
      res_chk_at = -1;
      rr_ptr     = 0;
      last_res   = '0;
    end else begin
      if (busy) chk("ready_busy", req_ready, 2'b00);
      else begin
        exp_g = 2'b00;
        if (rr_ptr == 0) exp_g = req_valid[0] ? 2'b01 : (req_valid[1] ? 2'b10 : 2'b00);
        else             exp_g = req_valid[1] ? 2'b10 : (req_valid[0] ? 2'b01 : 2'b00);
        chk("grant", req_ready, exp_g);
      end

      hs = req_valid & req_ready;
      if (hs != 2'b00) begin
        g = hs[1] ? 1 : 0;
        hs_cnt[g]++;
        hs_log_r.push_back(g);
        hs_log_c.push_back(cyc);
        rr_ptr = (g == 0) ? 1 : 0;
        busy   = 1'b1;
        infl   = cur_job[g];
        own_oh = (g == 0) ? 2'b01 : 2'b10;
        for (int k = 0; k < NB; k++)
          beat_q.push_back('{cyc + 1 + k, infl.data[4*k +: 4], infl.mode, (k == NB - 1)});
        if (infl.spur) spur_at = cyc + 2;
      end

      exp_civ = (beat_q.size() > 0) && (beat_q[0].cyc == cyc);
      chk("in_valid", core_in_valid, exp_civ);
      if (exp_civ) begin
        b = beat_q.pop_front();
        chk("in_number", core_in_number, b.nib);
        chk("in_mode", core_mode, b.mode);
        if (b.last) begin
          if (is_timeout(infl.dly)) rsp_q.push_back('{cyc + TO + 1, own_oh, 6'sd0, 1'b1});
          else                      fire_at = cyc + infl.dly;
        end
      end else if (busy) begin
        chk("in_number_quiet", core_in_number, 4'h0);
      end

      if (core_out_valid && cyc == fire_at) begin
        rsp_q.push_back('{cyc + 1, own_oh, infl.res, 1'b0});
        fire_at = -1;
      end
      if (core_out_valid && cyc == spur_at) begin
        res_chk_at = cyc + 1;
        spur_at    = -1;
      end
      if (cyc == res_chk_at) begin
        chk("res_hold", rsp_result, last_res);
        res_chk_at = -1;
      end

      exp_rv = (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) ? rsp_q[0].oh : 2'b00;
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv != 2'b00) begin
        rp = rsp_q.pop_front();
        chk("rsp_result", rsp_result, rp.res);
        chk("rsp_err", rsp_err, rp.err);
        busy     = 1'b0;
        last_res = rp.res;
      end
    end
  end

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(posedge clk); #1;
      done = (jq[0].size() == 0) && (jq[1].size() == 0) && !busy;
    end
    chk("drain", done, 1'b1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, req_ready, 2'b00);
    chk({tag, "_rspv"}, rsp_valid, 2'b00);
    chk({tag, "_res"}, rsp_result, 6'sd0);
    chk({tag, "_err"}, rsp_err, 1'b0);
    chk({tag, "_civ"}, core_in_valid, 1'b0);
    chk({tag, "_num"}, core_in_number, 4'h0);
    chk({tag, "_mode"}, core_mode, 2'b00);
  endtask

  initial begin : wdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int h;
    logic signed [5:0] neg32;
    neg32 = 6'b100000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    @(posedge clk); #1 rst = 1'b0;

    // single job on req0
    jq[0].push_back('{16'h4321, 2'b01, 6'sd10, 2, 1'b0});
    wait_idle(100);

    // stray core strobes in IDLE and during SEND
    spur_at = cyc + 2;
    repeat (4) @(posedge clk);
    #1;
    jq[0].push_back('{16'h9a5c, 2'b10, -6'sd5, 3, 1'b1});
    wait_idle(100);

    // contention from reset
    rst = 1'b1;
    jq[0].push_back('{16'h1111, 2'b00, 6'sd31, 2, 1'b0});
    jq[0].push_back('{16'h0f0f, 2'b11, -6'sd1, 4, 1'b0});
    jq[1].push_back('{16'hfedc, 2'b10, neg32, 1, 1'b0});
    jq[1].push_back('{16'h7777, 2'b01, 6'sd0, 3, 1'b0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    hs_log_r.delete();
    hs_log_c.delete();
    wait_idle(200);
    chk("cont_jobs", hs_log_r.size(), 4);
    for (int i = 0; i < hs_log_r.size() && i < 4; i++)
      chk("cont_order", hs_log_r[i], i % 2);

    // back-to-back on req1, core answers 1 cycle after last beat
    hs_log_r.delete();
    hs_log_c.delete();
    for (int i = 0; i < 3; i++)
      jq[1].push_back('{16'h2468 + 16'(i), 2'(i), 6'sd3 + 6'(i), 1, 1'b0});
    wait_idle(200);
    chk("b2b_jobs", hs_log_c.size(), 3);
    for (int i = 1; i < hs_log_c.size(); i++)
      chk("b2b_gap", hs_log_c[i] - hs_log_c[i-1], NB + 3);

    // reset during SEND beat 2, then req0 must win the next grant
    h = hs_cnt[0];
    jq[0].push_back('{16'h5555, 2'b11, 6'sd9, 2, 1'b0});
    for (int n = 0; n < 20 && hs_cnt[0] == h; n++) begin
      @(posedge clk); #1;
    end
    chk("rst_hs_seen", hs_cnt[0] != h, 1'b1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_quiet("midrst");
    repeat (8) @(posedge clk);
    #1;
    hs_log_r.delete();
    hs_log_c.delete();
    jq[1].push_back('{16'h1234, 2'b01, 6'sd7, 2, 1'b0});
    jq[0].push_back('{16'h4321, 2'b10, -6'sd7, 2, 1'b0});
    wait_idle(200);
    chk("rst_first", (hs_log_r.size() > 0) ? hs_log_r[0] : -1, 0);

`ifdef LAB06_SCHED_TIMEOUT_EN
    // silent core, then an answer exactly on the terminal cycle
    jq[0].push_back('{16'hcafe, 2'b01, 6'sd17, 0, 1'b0});
    wait_idle(TO + 40);
    jq[1].push_back('{16'hbeef, 2'b10, -6'sd12, TO, 1'b0});
    wait_idle(TO + 40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
